pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of the program counter and of every stack entry (>=2).
REQ-002 SHALL have parameter DEPTH, default 8, number of return-address stack entries (>=2).
REQ-003 SHALL have parameter STEP, default 1, increment added by inc and used to form the call return address (0 < STEP < 2^WIDTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of counter, stack and error flag.
REQ-007 SHALL have port load  input  1  jump: out takes in.
REQ-008 SHALL have port inc  input  1  advance out by STEP.
REQ-009 SHALL have port call  input  1  push out+STEP onto the stack, then jump to in.
REQ-010 SHALL have port ret  input  1  pop the stack top into out.
REQ-011 SHALL have port in  input  WIDTH  jump/call target.
REQ-012 SHALL have port out  output  WIDTH  current program counter, registered.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of valid stack entries.
REQ-014 SHALL have port full  output  1  high when count==DEPTH.
REQ-015 SHALL have port empty  output  1  high when count==0.
REQ-016 SHALL have port err  output  1  sticky overflow/underflow flag.

Function
REQ-017 SHALL evaluate controls each rising clk edge with strict priority clr > ret > call > load > inc > hold; only the highest asserted control takes effect.
REQ-018 SHALL on clr: out<=0, count<=0, err<=0.
REQ-019 SHALL on ret with count>0: out<=entry at top of stack, count<=count-1.
REQ-020 SHALL on ret with count==0: out and count unchanged, err<=1.
REQ-021 SHALL on call with count<DEPTH: write (out+STEP) mod 2^WIDTH at position count, count<=count+1, out<=in.
REQ-022 SHALL on call with count==DEPTH: no push, out and count unchanged, err<=1.
REQ-023 SHALL on load: out<=in; stack unaffected.
REQ-024 SHALL on inc: out<=(out+STEP) mod 2^WIDTH; wrap-around silent, err unaffected.
REQ-025 SHALL hold all state when no control is asserted.
REQ-026 SHALL operate the stack strictly LIFO; entries at positions >=count are unobservable.
REQ-027 SHALL make every state change visible on out/count one cycle after the controlling edge (single-cycle latency, no bypass from in to out).
REQ-028 SHALL derive full and empty combinationally from registered count only.
REQ-029 SHALL keep err set once set until clr or reset; a legal call/ret does not clear it.
REQ-030 SHALL, when call and ret are asserted together, perform only ret (underflow rules apply if empty).

Reset
REQ-031 SHALL on reset assertion immediately (no clk edge) force out=0, count=0, err=0, giving full=0, empty=1.
REQ-032 SHALL ignore all controls while reset is high and resume on the first rising clk edge after deassertion.
REQ-033 SHALL not require stack storage to be reset; contents are undefined after reset but never visible.

Verification (WIDTH=16, DEPTH=4, STEP=1)
REQ-034 SHALL verify count-up: reset, inc for 3 cycles -> out 0x0001, 0x0002, 0x0003; empty=1 throughout.
REQ-035 SHALL verify call/ret: load 0x0100, call in=0x0200 -> out=0x0200, count=1; ret -> out=0x0101, count=0, err=0.
REQ-036 SHALL verify wrap: load 0xFFFF, inc -> out=0x0000, err=0.
REQ-037 SHALL verify overflow/LIFO: from out=0x0010, call in=0x0020,0x0030,0x0040,0x0050 -> full=1; 5th call in=0x0060 -> out=0x0050, count=4, err=1; 4 rets -> out 0x0041, 0x0031, 0x0021, 0x0011, empty=1.
REQ-038 SHALL verify underflow and priority: empty stack, ret -> out held, err=1; clr with inc and call high -> out=0x0000, count=0, err=0; call+ret with count=1 -> pop only.
REQ-039 SHALL verify async reset mid-operation: with count=2 and out=0x1234, pulse reset between clk edges -> out=0, count=0, empty=1 before next edge; a following ret sets err=1.

Source files
------------

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with LIFO return-address stack
module pc_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int STEP  = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr,
   input  logic                       load,
   input  logic                       inc,
   input  logic                       call,
   input  logic                       ret,
   input  logic [WIDTH-1:0]           in,
   output logic [WIDTH-1:0]           out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]    ONE_C   = CW'(1);

   // Storage is never reset: entries at or above count are never read.
   logic [WIDTH-1:0] stack_mem [DEPTH];
   logic [WIDTH-1:0] ret_addr;
   logic [WIDTH-1:0] top;
   logic             push;

   assign ret_addr = out + STEP_W;
   assign top      = stack_mem[AW'(count - ONE_C)];
   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);

   // A push happens only when call wins the priority chain and there is room.
   assign push = !reset && !clr && !ret && call && !full;

   // Return-address storage, written at the current fill level.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[AW'(count)] <= ret_addr;
      end
   end

   // Counter, fill level and sticky error with priority clr > ret > call > load > inc.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out   <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (clr) begin
         out   <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (ret) begin
         if (!empty) begin
            out   <= top;
            count <= count - ONE_C;
         end else begin
            err <= 1'b1;
         end
      end else if (call) begin
         if (!full) begin
            out   <= in;
            count <= count + ONE_C;
         end else begin
            err <= 1'b1;
         end
      end else if (load) begin
         out <= in;
      end else if (inc) begin
         out <= ret_addr;
      end
   end

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - randomized scoreboard bench for pc_stack
module tb_pc_stack;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int STEP  = 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int MASK  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clr = 1'b0, load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
   logic [WIDTH-1:0] in = '0;
   logic [WIDTH-1:0] out;
   logic [CW-1:0]    count;
   logic             full, empty, err;

   typedef struct {
      int    pc;
      int    cnt;
      bit    full;
      bit    empty;
      bit    err;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic kick = 1'b0;

   // Reference model state: plain integer pc and a queue used as the stack.
   int   m_pc = 0;
   int   m_stack[$];
   bit   m_err = 0;

   pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP(STEP)) dut (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .inc(inc),
      .call(call), .ret(ret), .in(in), .out(out), .count(count),
      .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   function automatic exp_t snapshot(string tag);
      exp_t e;
      e.pc    = m_pc;
      e.cnt   = m_stack.size();
      e.full  = (m_stack.size() == DEPTH);
      e.empty = (m_stack.size() == 0);
      e.err   = m_err;
      e.tag   = tag;
      return e;
   endfunction

   task automatic chk(string name, string field, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s.%s got=0x%0h expected=0x%0h", name, field, got, want);
      end
   endtask

   // Monitor: whenever the DUT has been updated, pop the oldest expectation and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge kick);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "out",   int'(out),   e.pc);
            chk(e.tag, "count", int'(count), e.cnt);
            chk(e.tag, "full",  int'(full),  int'(e.full));
            chk(e.tag, "empty", int'(empty), int'(e.empty));
            chk(e.tag, "err",   int'(err),   int'(e.err));
         end
      end
   end

   // One clock of stimulus: drive on the falling edge, advance the model, queue the result.
   task automatic op(string tag, bit c_clr, bit c_ret, bit c_call, bit c_load, bit c_inc, int target);
      @(negedge clk);
      clr = c_clr; ret = c_ret; call = c_call; load = c_load; inc = c_inc;
      in  = target[WIDTH-1:0];
      if (c_clr) begin
         m_pc = 0; m_stack.delete(); m_err = 0;
      end else if (c_ret) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else m_err = 1;
      end else if (c_call) begin
         if (m_stack.size() < DEPTH) begin
            m_stack.push_back((m_pc + STEP) & MASK);
            m_pc = target & MASK;
         end else begin
            m_err = 1;
         end
      end else if (c_load) begin
         m_pc = target & MASK;
      end else if (c_inc) begin
         m_pc = (m_pc + STEP) & MASK;
      end
      exp_q.push_back(snapshot(tag));
   endtask

   // Reset pulse strictly between clock edges; state must clear with no edge.
   task automatic pulse_reset(string tag);
      @(negedge clk);
      clr = 0; ret = 0; call = 0; load = 0; inc = 0;
      #1;
      reset = 1'b1;
      m_pc = 0; m_stack.delete(); m_err = 0;
      exp_q.push_back(snapshot(tag));
      kick = 1'b1;
      #2;
      reset = 1'b0;
      kick  = 1'b0;
   endtask

   initial begin
      int r;
      // Power-up reset state, checked before any clock edge.
      #1;
      exp_q.push_back(snapshot("reset_state"));
      kick = 1'b1;
      #2;
      kick = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Count-up from reset.
      op("countup1", 0, 0, 0, 0, 1, 0);
      op("countup2", 0, 0, 0, 0, 1, 0);
      op("countup3", 0, 0, 0, 0, 1, 0);

      // Single call/return.
      op("cr_load", 0, 0, 0, 1, 0, 'h0100);
      op("cr_call", 0, 0, 1, 0, 0, 'h0200);
      op("cr_ret",  0, 1, 0, 0, 0, 0);

      // Silent wrap.
      op("wrap_load", 0, 0, 0, 1, 0, 'hFFFF);
      op("wrap_inc",  0, 0, 0, 0, 1, 0);

      // Fill, overflow, then unwind LIFO.
      op("ov_load",  0, 0, 0, 1, 0, 'h0010);
      op("ov_call1", 0, 0, 1, 0, 0, 'h0020);
      op("ov_call2", 0, 0, 1, 0, 0, 'h0030);
      op("ov_call3", 0, 0, 1, 0, 0, 'h0040);
      op("ov_call4", 0, 0, 1, 0, 0, 'h0050);
      op("ov_call5", 0, 0, 1, 0, 0, 'h0060);
      for (int i = 0; i < 4; i++) op($sformatf("ov_ret%0d", i), 0, 1, 0, 0, 0, 0);

      // Underflow, clear priority, call+ret pops only.
      op("uf_clr",    1, 0, 0, 0, 0, 0);
      op("uf_load",   0, 0, 0, 1, 0, 'h0777);
      op("uf_ret",    0, 1, 0, 0, 0, 0);
      op("uf_sticky", 0, 0, 0, 0, 1, 0);
      op("pri_clr",   1, 0, 1, 0, 1, 'h0abc);
      op("pri_call",  0, 0, 1, 0, 0, 'h0500);
      op("pri_both",  0, 1, 1, 1, 1, 'h0900);

      // Asynchronous reset in mid-operation.
      op("ar_call1", 0, 0, 1, 0, 0, 'h0001);
      op("ar_call2", 0, 0, 1, 0, 0, 'h1234);
      pulse_reset("ar_reset");
      op("ar_ret", 0, 1, 0, 0, 0, 0);

      // Randomized traffic with occasional clears and reset pulses.
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            pulse_reset("rnd_reset");
         end else begin
            op("rnd",
               ($urandom_range(0, 99) < 3),
               ($urandom_range(0, 99) < 30),
               ($urandom_range(0, 99) < 30),
               ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 50),
               int'($urandom_range(0, MASK)));
         end
      end

      @(negedge clk);
      clr = 0; ret = 0; call = 0; load = 0; inc = 0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
